// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } ssub_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// Single-bit full subtractor: d = x - y - bi, with borrow-out.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bi;
  assign bout = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin: one fs_cell, LSB first, WIDTH cycles per operation.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dif,
  output logic             bo,
  output logic             ovf
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  ssub_state_t      state, next_state;
  logic             load, step, last;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             borrow, a_msb, b_msb;
  logic [CW-1:0]    count;
  logic             d_bit, b_out;

  fs_cell u_fs (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bi   (borrow),
    .d    (d_bit),
    .bout (b_out)
  );

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = SHIFT;
          load       = 1'b1;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (count == LAST) next_state = DONE;
      end
      DONE: begin
        if (start) begin
          next_state = SHIFT;
          load       = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);
  assign last = step && (count == LAST);

  // The a register doubles as the partial-difference register: diff bits
  // enter at the MSB as the consumed minuend bits leave at the LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      borrow <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      count  <= '0;
      dif    <= '0;
      bo     <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (load) begin
        a_sh   <= a;
        b_sh   <= b;
        borrow <= bin;
        a_msb  <= a[WIDTH-1];
        b_msb  <= b[WIDTH-1];
        count  <= '0;
      end else if (step) begin
        a_sh   <= {d_bit, a_sh[WIDTH-1:1]};
        b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
        borrow <= b_out;
        count  <= count + 1'b1;
      end
      if (last) begin
        dif <= {d_bit, a_sh[WIDTH-1:1]};
        bo  <= b_out;
        ovf <= (a_msb != b_msb) && (d_bit != a_msb);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: directed cases and random ops at WIDTH=8, exhaustive sweep at WIDTH=4.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start8, bin8, busy8, done8, bo8, ovf8;
  logic [7:0] a8, b8, dif8;
  logic       start4, bin4, busy4, done4, bo4, ovf4;
  logic [3:0] a4, b4, dif4;

  int tests = 0;
  int fails = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .dif(dif8), .bo(bo8), .ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .dif(dif4), .bo(bo4), .ovf(ovf4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic void ref_sub(input int w, input longint a, input longint b, input int bin,
                                  output longint d, output logic bo, output logic ovf);
    longint m;
    longint sa, sb, sr;
    m   = longint'(1) << w;
    d   = ((a - b - bin) % m + m) % m;
    bo  = (a < b + bin);
    sa  = (a >= m / 2) ? a - m : a;
    sb  = (b >= m / 2) ? b - m : b;
    sr  = sa - sb - bin;
    ovf = (sr < -(m / 2)) || (sr >= m / 2);
  endfunction

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin, input string tag);
    longint ed;
    logic   eb, eo;
    int     k;
    ref_sub(8, a, b, bin, ed, eb, eo);
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = ~bin;
    check({tag, "_busy"}, busy8, 1);
    k = 0;
    while (!done8 && k < 24) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, k, 8);
    check({tag, "_dif"}, dif8, ed);
    check({tag, "_bo"}, bo8, eb);
    check({tag, "_ovf"}, ovf8, eo);
    @(negedge clk);
    check({tag, "_pulse"}, done8, 0);
    check({tag, "_hold"}, dif8, ed);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bin);
    longint ed;
    logic   eb, eo;
    int     k;
    ref_sub(4, a, b, bin, ed, eb, eo);
    @(negedge clk);
    a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    k = 0;
    while (!done4 && k < 12) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    check($sformatf("w4_%0h_%0h_%0d_lat", a, b, bin), k, 4);
    check($sformatf("w4_%0h_%0h_%0d_dif", a, b, bin), dif4, ed);
    check($sformatf("w4_%0h_%0h_%0d_bo", a, b, bin), bo4, eb);
    check($sformatf("w4_%0h_%0h_%0d_ovf", a, b, bin), ovf4, eo);
  endtask

  initial begin
    int k;
    int seen;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_dif", dif8, 0);
    check("rst_bo", bo8, 0);
    check("rst_ovf", ovf8, 0);
    check("rst_dif4", dif4, 0);

    run8(8'd100, 8'd37, 1'b0, "sub_100_37");
    run8(8'h05, 8'h07, 1'b1, "sub_05_07_bin");
    run8(8'h80, 8'h01, 1'b0, "ovf_80_01");
    run8(8'h7F, 8'hFF, 1'b0, "ovf_7f_ff");
    run8(8'h3C, 8'h3C, 1'b1, "eq_bin_wrap");

    // start pulses while busy must be ignored
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd37; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    k = 0;
    while (!done8 && k < 24) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (k == 2 || k == 5) begin
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h11;
      end else begin
        start8 = 1'b0;
      end
    end
    check("busy_start_latency", k, 8);
    check("busy_start_dif", dif8, 8'd63);
    @(negedge clk);
    check("busy_start_idle", busy8, 0);
    check("busy_start_done_low", done8, 0);

    // back-to-back: start held in the DONE cycle
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    k = 0;
    while (!done8 && k < 24) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    check("b2b_first_latency", k, 8);
    a8 = 8'h7F; b8 = 8'hFF; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    check("b2b_busy", busy8, 1);
    check("b2b_done_low", done8, 0);
    check("b2b_first_dif_held", dif8, 8'h7F);
    check("b2b_first_ovf_held", ovf8, 1);
    k = 0;
    while (!done8 && k < 24) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (k == 6) check("b2b_mid_dif_held", dif8, 8'h7F);
    end
    check("b2b_second_latency", k, 8);
    check("b2b_second_dif", dif8, 8'h80);
    check("b2b_second_bo", bo8, 1);
    check("b2b_second_ovf", ovf8, 1);

    // reset during SHIFT aborts with no done pulse
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd3; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_dif", dif8, 0);
    check("abort_bo", bo8, 0);
    check("abort_ovf", ovf8, 0);
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) seen++;
    end
    check("abort_no_done", seen, 0);
    run8(8'd9, 8'd9, 1'b1, "after_abort");

    for (int i = 0; i < 24; i++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rand%0d", i));
    end

    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          run4(4'(ai), 4'(bi), 1'(ci));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
